// File: rtl/score_entry.sv
// Score-entry conditioner: synchronises switches and submit key, debounces the key,
// and sequences one round of NJUDGE non-zero judge scores into a clean scorein/submit pair.
module score_entry #(
    parameter int unsigned DB_CNT = 1000000,
    parameter int unsigned NJUDGE = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       key,
    input  logic       clr,
    output logic [3:0] scorein,
    output logic       submit,
    output logic       reject,
    output logic [2:0] judge_idx,
    output logic       done
);
    localparam int unsigned DB_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CNT - 1);
    localparam logic [2:0] NJ = 3'(NJUDGE);

    typedef enum logic [1:0] {WAIT, HOLD, LOCK} state_t;

    logic [3:0]      sw_m, sw_s;
    logic            key_m, key_s;
    logic            key_db, key_db_q;
    logic [DB_W-1:0] db;

    state_t     state, state_nxt;
    logic [3:0] scorein_nxt;
    logic       submit_nxt, reject_nxt, done_nxt;
    logic [2:0] judge_idx_nxt;

    // Two-flop synchronisers and key debounce counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m     <= 4'd0;
            sw_s     <= 4'd0;
            key_m    <= 1'b0;
            key_s    <= 1'b0;
            key_db   <= 1'b0;
            key_db_q <= 1'b0;
            db       <= '0;
        end else begin
            sw_m     <= sw;
            sw_s     <= sw_m;
            key_m    <= key;
            key_s    <= key_m;
            key_db_q <= key_db;
            if (key_s == key_db) begin
                db <= '0;
            end else if (db == DB_MAX) begin
                key_db <= key_s;
                db     <= '0;
            end else begin
                db <= db + DB_W'(1);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT;
            scorein   <= 4'd0;
            submit    <= 1'b0;
            reject    <= 1'b0;
            judge_idx <= 3'd0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            scorein   <= scorein_nxt;
            submit    <= submit_nxt;
            reject    <= reject_nxt;
            judge_idx <= judge_idx_nxt;
            done      <= done_nxt;
        end
    end

    // Next state: one action per debounced press; clr overrides any action
    always_comb begin
        state_nxt     = state;
        scorein_nxt   = scorein;
        submit_nxt    = 1'b0;
        reject_nxt    = 1'b0;
        judge_idx_nxt = judge_idx;
        done_nxt      = done;

        case (state)
            WAIT: begin
                if (key_db) begin
                    if ((sw_s != 4'd0) && (judge_idx < NJ)) begin
                        scorein_nxt   = sw_s;
                        submit_nxt    = 1'b1;
                        judge_idx_nxt = judge_idx + 3'd1;
                        if ((judge_idx + 3'd1) == NJ) begin
                            done_nxt  = 1'b1;
                            state_nxt = LOCK;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end else begin
                        reject_nxt = 1'b1;
                        state_nxt  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!key_db) state_nxt = WAIT;
            end
            LOCK: begin
                if (key_db && !key_db_q) reject_nxt = 1'b1;
            end
            default: state_nxt = WAIT;
        endcase

        if (clr) begin
            scorein_nxt   = 4'd0;
            submit_nxt    = 1'b0;
            reject_nxt    = 1'b0;
            judge_idx_nxt = 3'd0;
            done_nxt      = 1'b0;
            state_nxt     = key_db ? HOLD : WAIT;
        end
    end
endmodule

// File: doc/score_entry.md
# score_entry

Input conditioner that sits directly upstream of the 7-judge scoring block. It converts raw board inputs into that block's clean `scorein`/`submit` pair: a 4-bit score switch bank and a bouncy submit key. It synchronises both, debounces the key, and rejects a score of 0. It also sequences a round of exactly 7 accepted judge scores and locks out further entries until the round is cleared.

## Interface
- `DB_CNT`, default 1000000 — consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); the bench uses 4.
- `NJUDGE`, default 7 — accepted scores per round.

- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `sw` in 4 — raw score switches, asynchronous.
- `key` in 1 — raw submit key, active-high, asynchronous, bouncy.
- `clr` in 1 — synchronous round clear, active-high, already clean.
- `scorein` out 4 — last accepted score; feeds the scoring block.
- `submit` out 1 — one-cycle pulse marking a newly accepted `scorein`.
- `reject` out 1 — one-cycle pulse: press refused (score 0, or round done).
- `judge_idx` out 3 — number of scores accepted this round, 0..NJUDGE.
- `done` out 1 — high once NJUDGE scores are accepted.

## Operation
- **Synchronisers:** `sw` and `key` each pass through a 2-flop synchroniser, giving `sw_s` and `key_s`.
- **Debounce:**
  - The counter `db` increments every cycle that `key_s != key_db`.
  - `db` clears to 0 on any cycle `key_s == key_db`.
  - When `db == DB_CNT-1` and the inputs still differ, `key_db <= key_s` and `db <= 0`.
  - A pulse shorter than DB_CNT stable cycles never changes `key_db`.
- **FSM states:** WAIT, HOLD, LOCK.
  - **WAIT**, when `key_db == 1`:
    - If `sw_s != 0` and `judge_idx < NJUDGE`: `scorein <= sw_s`, `submit <= 1`, `judge_idx <= judge_idx+1`. If the new count equals NJUDGE, `done <= 1` and go to LOCK; otherwise go to HOLD.
    - If `sw_s == 0`: `reject <= 1`, go to HOLD; `scorein` and `judge_idx` are unchanged.
  - **HOLD:** wait for `key_db == 0`, then go to WAIT. This gives one action per press, however long the key is held.
  - **LOCK:** each `key_db` 0→1 transition pulses `reject`; never pulses `submit`.
- `submit` and `reject` are registered, high for exactly one cycle, and never high together.
- `scorein` is stable from its `submit` edge until the next accept; `sw` changes in between are ignored.
- **`clr`:**
  - Sets `judge_idx` to 0, `done` to 0, `scorein` to 0; suppresses `submit`/`reject` that cycle.
  - Next state is HOLD if `key_db == 1`, else WAIT, so a held key never auto-submits.
  - Does not touch the synchronisers or the debounce state.
- **Simultaneous events:** `rst` beats `clr`; `clr` beats an accept or reject in the same cycle.

## Timing
- **Reset values:** `scorein` 0, `submit` 0, `reject` 0, `judge_idx` 0, `done` 0. Internal state: `key_db` 0, `db` 0, synchronisers 0, FSM WAIT.
- **Latency:** let edge 0 be the first edge sampling `key == 1`, with `key` and `sw` stable thereafter.
  - `key_s` is high after edge 1.
  - `key_db` is high after edge DB_CNT+1.
  - `submit` is high for the cycle following edge DB_CNT+2.
  - With DB_CNT=4: `submit` is high between edges 6 and 7.
- **Release:** the release is debounced identically; the next press is accepted only after `key_db` has returned to 0.
- **`sw` setup:** `sw` must be stable at least 2 cycles before the accept edge to be captured.
- **Reset mid-debounce:** a partially counted press is discarded, and the key must be re-qualified from `key_db = 0`. If the key is held through reset, it is accepted once DB_CNT+2 edges after reset deasserts.

## Test plan
1. **Reset:** assert `rst` with `key=1`, `sw=9`. Every output holds its reset value while `rst` is high, and no `submit` occurs before DB_CNT+2 edges after release.
2. **Clean press (DB_CNT=4):** `sw=9`, `key` high for 20 cycles. Exactly one `submit` pulse, 6 edges after the first `key=1` sample. `scorein=9`, `judge_idx` 0→1, no `reject`.
3. **Bounce:** `key` toggles 1,1,0,1,0,1,1,0 per cycle, then stays 0. No `submit`, no `reject`. Then a clean press with `sw=15` gives a single `submit` with `scorein=15`.
4. **Zero score:** `sw=0`, clean press. Exactly one `reject` pulse; `scorein` keeps its prior value; `judge_idx` is unchanged.
5. **Full round:** seven clean presses with `sw` = 3,15,1,8,8,12,5.
   - Seven `submit` pulses with those `scorein` values.
   - `judge_idx` reaches 7 and `done` rises on the 7th accept.
   - An 8th press (`sw=6`) gives one `reject`, no `submit`, and `scorein` stays 5.
6. **Held key and clear:** hold `key` for 10×DB_CNT cycles and assert `clr` mid-hold. Only one `submit` (before `clr`); `judge_idx` ends at 0. After release and a fresh press, `judge_idx` = 1.
